// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the Pong display path.
// Defaults describe 640x480@60 with a 25 MHz pixel rate derived from 100 MHz.
package vga_timing_pkg;

   localparam int COORD_W   = 10;
   localparam int MAX_TOTAL = 1 << COORD_W;

   typedef logic [COORD_W-1:0] coord_t;

   localparam int DEF_CLK_DIV   = 4;
   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;
   localparam logic DEF_SYNC_POL = 1'b0;

   localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   localparam int DEF_HSYNC_FIRST = DEF_H_DISPLAY + DEF_H_FRONT;
   localparam int DEF_HSYNC_LAST  = DEF_HSYNC_FIRST + DEF_H_SYNC - 1;
   localparam int DEF_VSYNC_FIRST = DEF_V_DISPLAY + DEF_V_FRONT;
   localparam int DEF_VSYNC_LAST  = DEF_VSYNC_FIRST + DEF_V_SYNC - 1;

   // Drives the sync line to its active level only inside the inclusive window.
   function automatic logic syncLevel(input coord_t pos, input coord_t first,
                                      input coord_t last, input logic pol);
      return ((pos >= first) && (pos <= last)) ? pol : ~pol;
   endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-clock-wide pixel-rate enable.
module pixel_tick_gen #(
   parameter int CLK_DIV = 4
)(
   input  logic clk,
   input  logic reset,
   output logic p_tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_divCnt;
   logic             w_divWrap;

   // With CLK_DIV=1 the counter is pinned at zero, so the tick is constantly high.
   assign w_divWrap = (r_divCnt == DIV_MAX);
   assign p_tick    = w_divWrap;

   always_ff @(posedge clk) begin
      if (reset || w_divWrap) begin
         r_divCnt <= '0;
      end else begin
         r_divCnt <= r_divCnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel/line counters, sync and blanking decode, strobes.
// Sync and video_on are registered from the next-count values so they never skew from pixel_x/pixel_y.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int   CLK_DIV   = DEF_CLK_DIV,
   parameter int   H_DISPLAY = DEF_H_DISPLAY,
   parameter int   H_FRONT   = DEF_H_FRONT,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BACK    = DEF_H_BACK,
   parameter int   V_DISPLAY = DEF_V_DISPLAY,
   parameter int   V_FRONT   = DEF_V_FRONT,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BACK    = DEF_V_BACK,
   parameter logic SYNC_POL  = DEF_SYNC_POL
)(
   input  logic               clk,
   input  logic               reset,
   output logic               p_tick,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               video_on,
   output logic               hsync,
   output logic               vsync,
   output logic               line_tick,
   output logic               frame_tick
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_badTotal
      $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed %0d", MAX_TOTAL);
   end
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_badDiv
      $error("vga_sync_gen: CLK_DIV must be in 1..16");
   end
   if (H_SYNC < 1 || V_SYNC < 1 || H_DISPLAY < 1 || V_DISPLAY < 1) begin : g_badWidth
      $error("vga_sync_gen: display and sync widths must be at least 1");
   end

   localparam coord_t H_LAST      = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST      = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS       = coord_t'(H_DISPLAY);
   localparam coord_t V_VIS       = coord_t'(V_DISPLAY);
   localparam coord_t HSYNC_FIRST = coord_t'(H_DISPLAY + H_FRONT);
   localparam coord_t HSYNC_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam coord_t VSYNC_FIRST = coord_t'(V_DISPLAY + V_FRONT);
   localparam coord_t VSYNC_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   coord_t r_hCnt;
   coord_t r_vCnt;
   logic   r_videoOn;
   logic   r_hsync;
   logic   r_vsync;

   coord_t w_hNext;
   coord_t w_vNext;
   logic   w_hLast;
   logic   w_vLast;
   logic   w_pTick;

   pixel_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pixelTick (
      .clk    (clk),
      .reset  (reset),
      .p_tick (w_pTick)
   );

   assign w_hLast = (r_hCnt == H_LAST);
   assign w_vLast = (r_vCnt == V_LAST);

   always_comb begin
      w_hNext = r_hCnt;
      w_vNext = r_vCnt;
      if (w_pTick) begin
         if (w_hLast) begin
            w_hNext = '0;
            w_vNext = w_vLast ? '0 : r_vCnt + coord_t'(1);
         end else begin
            w_hNext = r_hCnt + coord_t'(1);
         end
      end
   end

   // Reset lands on (0,0), which is visible and outside both sync windows.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hCnt    <= '0;
         r_vCnt    <= '0;
         r_videoOn <= 1'b1;
         r_hsync   <= ~SYNC_POL;
         r_vsync   <= ~SYNC_POL;
      end else begin
         r_hCnt    <= w_hNext;
         r_vCnt    <= w_vNext;
         r_videoOn <= (w_hNext < H_VIS) && (w_vNext < V_VIS);
         r_hsync   <= syncLevel(w_hNext, HSYNC_FIRST, HSYNC_LAST, SYNC_POL);
         r_vsync   <= syncLevel(w_vNext, VSYNC_FIRST, VSYNC_LAST, SYNC_POL);
      end
   end

   assign p_tick     = w_pTick;
   assign pixel_x    = r_hCnt;
   assign pixel_y    = r_vCnt;
   assign video_on   = r_videoOn;
   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign line_tick  = w_pTick & w_hLast;
   assign frame_tick = w_pTick & w_hLast & w_vLast;

endmodule
